alt_vipvfr131_common_multi_trigger_sync: RTL and testbench

Multi-channel, loss-free trigger crossing from `input_clock` to `sync_clock`. Each channel counts trigger events in the source domain and replays them one at a time in the destination domain over a 2-phase req/ack handshake, so closely spaced triggers are queued rather than lost. It sits between the VFR control/register front end and the frame-reader and writer engines, where several independent go/stop/irq events cross clock domains.

---
 rtl/alt_vipvfr131_common_multi_trigger_sync.sv | 228 ++++++++++++++++++++++
 tb/tb_alt_vipvfr131_common_multi_trigger_sync.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_vipvfr131_common_multi_trigger_sync.sv
// alt_vipvfr131_common_multi_trigger_sync
// Loss-free, multi-channel trigger crossing from input_clock to sync_clock.
// Each channel counts trigger events in the source domain. It replays them one
// at a time over a two-phase (toggle) req/ack handshake, so a burst of triggers
// is queued rather than merged. The destination sees one trigger_out pulse per
// event, up to the saturation point of the pending counter.

// ---------------------------------------------------------------------------
// Plain flop-chain synchroniser. The chain is only instantiated when STAGES>=2.
// The same-clock bypass is handled by the caller, not here.
// ---------------------------------------------------------------------------
module alt_vipvfr131_common_multi_trigger_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the metastability chain
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// ---------------------------------------------------------------------------
// One trigger channel: the event counter and toggle request live on the source
// side. The edge detector for req_s lives on the destination side.
// ---------------------------------------------------------------------------
module alt_vipvfr131_common_multi_trigger_sync_channel #(
    parameter int COUNT_WIDTH = 4,
    parameter int SYNC_DEPTH  = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic                   input_clock,
    input  logic                   input_rst,
    input  logic                   sync_clock,
    input  logic                   rst,
    input  logic                   trigger_in,
    input  logic                   clear_overflow,
    output logic [COUNT_WIDTH-1:0] pending,
    output logic                   overflow,
    output logic                   trigger_out
);

    // Source-side handshake states. They are decoded from req/ack_s and the
    // counter, not stored.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic                   trig_reg;
    logic                   req;
    logic                   ack_s;
    logic                   req_s;
    logic                   req_s_d;
    logic [COUNT_WIDTH-1:0] count;
    logic                   event_hit;
    logic                   launch;
    logic                   at_max;
    logic [1:0]             state;

    // -------------------------------------------------------------------
    // Source domain
    // -------------------------------------------------------------------
    assign event_hit = (EDGE_MODE != 0) ? (trigger_in & ~trig_reg) : trigger_in;
    assign at_max    = &count;

    // Decode the handshake state. BUSY means a toggle is still in flight.
    always_comb begin
        state = ST_IDLE;
        if (req != ack_s) begin
            state = ST_BUSY;
        end else if (count != '0) begin
            state = ST_READY;
        end
    end

    // A new toggle is launched only from READY. The counter is registered, so
    // an event seen at edge k launches at edge k+1 at the earliest.
    assign launch = (state == ST_READY);

    // Trigger history for edge detection, and the toggling request
    always_ff @(posedge input_clock or posedge input_rst) begin
        if (input_rst) begin
            trig_reg <= 1'b0;
            req      <= 1'b0;
        end else begin
            trig_reg <= trigger_in;
            req      <= req ^ launch;
        end
    end

    // Pending-event counter. An event that lands on a full counter with no
    // launch to drain it is dropped.
    always_ff @(posedge input_clock or posedge input_rst) begin
        if (input_rst) begin
            count <= '0;
        end else begin
            case ({event_hit, launch})
                2'b10:   if (!at_max) count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag. A new drop takes priority over a simultaneous clear.
    always_ff @(posedge input_clock or posedge input_rst) begin
        if (input_rst) begin
            overflow <= 1'b0;
        end else if (event_hit && !launch && at_max) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign pending = count;

    // -------------------------------------------------------------------
    // Crossings. A depth of 0 means both sides share one clock net, so the
    // toggles are passed straight through.
    // -------------------------------------------------------------------
    generate
        if (SYNC_DEPTH == 0) begin : g_bypass
            assign req_s = req;
            assign ack_s = req_s_d;
        end else begin : g_sync
            alt_vipvfr131_common_multi_trigger_sync_chain #(
                .STAGES (SYNC_DEPTH)
            ) u_req_sync (
                .clock (sync_clock),
                .rst   (rst),
                .din   (req),
                .dout  (req_s)
            );

            alt_vipvfr131_common_multi_trigger_sync_chain #(
                .STAGES (SYNC_DEPTH)
            ) u_ack_sync (
                .clock (input_clock),
                .rst   (input_rst),
                .din   (req_s_d),
                .dout  (ack_s)
            );
        end
    endgenerate

    // -------------------------------------------------------------------
    // Destination domain
    // -------------------------------------------------------------------

    // Delayed copy of the synchronised request. It also serves as the ack
    // toggle sent back to the source.
    always_ff @(posedge sync_clock or posedge rst) begin
        if (rst) begin
            req_s_d <= 1'b0;
        end else begin
            req_s_d <= req_s;
        end
    end

    // Every toggle of req_s produces a one-cycle pulse
    assign trigger_out = req_s ^ req_s_d;

endmodule

// ---------------------------------------------------------------------------
// Top level: CHANNELS independent copies of the channel.
// ---------------------------------------------------------------------------
module alt_vipvfr131_common_multi_trigger_sync #(
    parameter int CHANNELS        = 4,
    parameter int COUNT_WIDTH     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_MODE       = 1,
    parameter int CLOCKS_ARE_SAME = 0
) (
    input  logic                            input_clock,
    input  logic                            input_rst,
    input  logic                            sync_clock,
    input  logic                            rst,
    input  logic [CHANNELS-1:0]             trigger_in,
    input  logic [CHANNELS-1:0]             clear_overflow,
    output logic [CHANNELS*COUNT_WIDTH-1:0] pending,
    output logic [CHANNELS-1:0]             overflow,
    output logic [CHANNELS-1:0]             trigger_out
);

    // Clamp the synchroniser depth to 2..4. A shared clock needs no synchroniser.
    localparam int SYNC_CLAMP = (SYNC_STAGES < 2) ? 2 :
                                (SYNC_STAGES > 4) ? 4 : SYNC_STAGES;
    localparam int SYNC_DEPTH = (CLOCKS_ARE_SAME != 0) ? 0 : SYNC_CLAMP;

    genvar ch;
    generate
        for (ch = 0; ch < CHANNELS; ch++) begin : g_ch
            alt_vipvfr131_common_multi_trigger_sync_channel #(
                .COUNT_WIDTH (COUNT_WIDTH),
                .SYNC_DEPTH  (SYNC_DEPTH),
                .EDGE_MODE   (EDGE_MODE)
            ) u_channel (
                .input_clock    (input_clock),
                .input_rst      (input_rst),
                .sync_clock     (sync_clock),
                .rst            (rst),
                .trigger_in     (trigger_in[ch]),
                .clear_overflow (clear_overflow[ch]),
                .pending        (pending[ch*COUNT_WIDTH +: COUNT_WIDTH]),
                .overflow       (overflow[ch]),
                .trigger_out    (trigger_out[ch])
            );
        end
    endgenerate

endmodule

// File: tb/tb_alt_vipvfr131_common_multi_trigger_sync.sv
// Bench for alt_vipvfr131_common_multi_trigger_sync.
// Four instances cover the distinct configurations:
//   A: defaults, async 14 ns sync clock
//   B: level mode, sync clock 3x slower
//   C: shared clock, level mode, 2-bit counter (cycle-exact table)
//   D: 2-bit counter, edge mode, slow sync clock (saturation)
module tb_alt_vipvfr131_common_multi_trigger_sync;

    logic clk_i  = 1'b0;
    logic clk_sa = 1'b0;
    logic clk_s3 = 1'b0;
    logic clk_s5 = 1'b0;
    logic rst_i, rst_s;

    always #5 clk_i = ~clk_i;
    initial begin #2; forever #7  clk_sa = ~clk_sa; end
    initial begin #3; forever #15 clk_s3 = ~clk_s3; end
    initial begin #4; forever #25 clk_s5 = ~clk_s5; end

    // Instance A
    logic [3:0]  trig_a, clr_a, ovf_a, to_a;
    logic [15:0] pend_a;
    alt_vipvfr131_common_multi_trigger_sync dut_a (
        .input_clock(clk_i), .input_rst(rst_i), .sync_clock(clk_sa), .rst(rst_s),
        .trigger_in(trig_a), .clear_overflow(clr_a), .pending(pend_a),
        .overflow(ovf_a), .trigger_out(to_a));

    // Instance B
    logic [1:0] trig_b, clr_b, ovf_b, to_b;
    logic [7:0] pend_b;
    alt_vipvfr131_common_multi_trigger_sync #(
        .CHANNELS(2), .COUNT_WIDTH(4), .SYNC_STAGES(2), .EDGE_MODE(0), .CLOCKS_ARE_SAME(0)
    ) dut_b (
        .input_clock(clk_i), .input_rst(rst_i), .sync_clock(clk_s3), .rst(rst_s),
        .trigger_in(trig_b), .clear_overflow(clr_b), .pending(pend_b),
        .overflow(ovf_b), .trigger_out(to_b));

    // Instance C
    logic [0:0] trig_c, clr_c, ovf_c, to_c;
    logic [1:0] pend_c;
    alt_vipvfr131_common_multi_trigger_sync #(
        .CHANNELS(1), .COUNT_WIDTH(2), .SYNC_STAGES(2), .EDGE_MODE(0), .CLOCKS_ARE_SAME(1)
    ) dut_c (
        .input_clock(clk_i), .input_rst(rst_i), .sync_clock(clk_i), .rst(rst_s),
        .trigger_in(trig_c), .clear_overflow(clr_c), .pending(pend_c),
        .overflow(ovf_c), .trigger_out(to_c));

    // Instance D
    logic [0:0] trig_d, clr_d, ovf_d, to_d;
    logic [1:0] pend_d;
    alt_vipvfr131_common_multi_trigger_sync #(
        .CHANNELS(1), .COUNT_WIDTH(2), .SYNC_STAGES(2), .EDGE_MODE(1), .CLOCKS_ARE_SAME(0)
    ) dut_d (
        .input_clock(clk_i), .input_rst(rst_i), .sync_clock(clk_s5), .rst(rst_s),
        .trigger_in(trig_d), .clear_overflow(clr_d), .pending(pend_d),
        .overflow(ovf_d), .trigger_out(to_d));

    // Pulse counters in each destination domain, plus a count of stretched pulses
    int cnt_a [4];
    int cnt_b [2];
    int cnt_d;
    int wide_a;
    logic [3:0] prev_a = '0;

    always @(posedge clk_sa) begin
        for (int i = 0; i < 4; i++) begin
            if (to_a[i]) cnt_a[i] <= cnt_a[i] + 1;
        end
        if ((to_a & prev_a) != 4'b0) wide_a <= wide_a + 1;
        prev_a <= to_a;
    end

    always @(posedge clk_s3) begin
        for (int i = 0; i < 2; i++) begin
            if (to_b[i]) cnt_b[i] <= cnt_b[i] + 1;
        end
    end

    always @(posedge clk_s5) begin
        if (to_d[0]) cnt_d <= cnt_d + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       trig;
        logic       clr;
        logic [1:0] pend;
        logic       ovf;
        logic       tout;
    } vec_t;

    vec_t tbl [23];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base0, base1, base2, base3, peak, lat;
        logic seen;

        // Same-clock instance, one row per input_clock cycle:
        // trig, clr -> pending, overflow, trigger_out after the edge
        tbl[0]  = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b1}; // event + launch: unchanged
        tbl[2]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0}; // drop while full: set beats clear
        tbl[16] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

        rst_i = 1'b1; rst_s = 1'b1;
        trig_a = '0; clr_a = '0; trig_b = '0; clr_b = '0;
        trig_c = '0; clr_c = '0; trig_d = '0; clr_d = '0;

        // Reset state
        #1;
        chk("reset pend_a", pend_a, 0);
        chk("reset ovf_a", ovf_a, 0);
        chk("reset to_a", to_a, 0);
        chk("reset to_b/c/d", {to_b, to_c, to_d}, 0);
        chk("reset pend_c/d", {pend_c, pend_d}, 0);

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0; rst_s = 1'b0;
        repeat (3) @(negedge clk_i);

        // Same-clock instance, cycle-exact
        for (int i = 0; i < 23; i++) begin
            trig_c[0] = tbl[i].trig;
            clr_c[0]  = tbl[i].clr;
            @(posedge clk_i); #1;
            chk($sformatf("tbl[%0d] pending", i), pend_c, tbl[i].pend);
            chk($sformatf("tbl[%0d] overflow", i), ovf_c, tbl[i].ovf);
            chk($sformatf("tbl[%0d] trigger_out", i), to_c, tbl[i].tout);
            @(negedge clk_i);
        end

        // A: single edge on channel 0
        base0 = cnt_a[0]; base1 = cnt_a[1]; base2 = cnt_a[2]; base3 = cnt_a[3];
        trig_a[0] = 1'b1;
        @(posedge clk_i); #1;
        chk("a single pending after event", pend_a[3:0], 1);
        @(negedge clk_i); trig_a[0] = 1'b0;
        @(posedge clk_i); #1;
        chk("a single pending after launch", pend_a[3:0], 0);
        seen = 1'b0; lat = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(posedge clk_sa); #1;
            lat++;
            if (to_a[0]) seen = 1'b1;
        end
        chk("a single latency within 2..4", (seen && lat >= 2 && lat <= 4), 1);
        repeat (40) @(negedge clk_i);
        chk("a single pulses ch0", cnt_a[0] - base0, 1);
        chk("a single silent others", (cnt_a[1] - base1) + (cnt_a[2] - base2) + (cnt_a[3] - base3), 0);
        chk("a single pending idle", pend_a, 0);

        // A: held level counts as one event in edge mode
        base2 = cnt_a[2];
        trig_a[2] = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        chk("a held pending ch2", pend_a[11:8], 0);
        @(negedge clk_i); trig_a[2] = 1'b0;
        for (int t = 0; t < 200 && cnt_a[2] < base2 + 1; t++) @(negedge clk_i);
        repeat (40) @(negedge clk_i);
        chk("a held pulses ch2", cnt_a[2] - base2, 1);

        // A: concurrent channels, three queued edges on ch3
        base0 = cnt_a[0]; base1 = cnt_a[1]; base3 = cnt_a[3];
        for (int e = 0; e < 3; e++) begin
            @(negedge clk_i); trig_a[3] = 1'b1; trig_a[1] = (e == 0);
            @(negedge clk_i); trig_a[3] = 1'b0; trig_a[1] = 1'b0;
        end
        for (int t = 0; t < 400 && cnt_a[3] < base3 + 3; t++) @(negedge clk_i);
        repeat (40) @(negedge clk_i);
        chk("a multi pulses ch3", cnt_a[3] - base3, 3);
        chk("a multi pulses ch1", cnt_a[1] - base1, 1);
        chk("a multi silent ch0", cnt_a[0] - base0, 0);
        chk("a multi pending idle", pend_a, 0);
        chk("a multi overflow", ovf_a, 0);
        chk("a pulse width", wide_a, 0);

        // B: level mode, 5 cycles high, slow sync clock
        peak = 0;
        @(negedge clk_i); trig_b[1] = 1'b1;
        repeat (5) begin
            @(posedge clk_i); #1;
            if (int'(pend_b[7:4]) > peak) peak = int'(pend_b[7:4]);
        end
        @(negedge clk_i); trig_b[1] = 1'b0;
        $display("info: B pending peak %0d", peak);
        chk("b pending peak in 4..5", (peak >= 4 && peak <= 5), 1);
        for (int t = 0; t < 1000 && cnt_b[1] < 5; t++) @(negedge clk_i);
        repeat (60) @(negedge clk_i);
        chk("b pulses ch1", cnt_b[1], 5);
        chk("b silent ch0", cnt_b[0], 0);
        chk("b overflow", ovf_b, 0);
        chk("b pending idle", pend_b, 0);

        // D: saturation of a 2-bit counter while busy
        @(negedge clk_i); trig_d[0] = 1'b1;
        @(negedge clk_i); trig_d[0] = 1'b0;
        @(posedge clk_i); #1;
        chk("d pending after first launch", pend_d, 0);
        for (int e = 0; e < 6; e++) begin
            @(negedge clk_i); trig_d[0] = 1'b1;
            @(posedge clk_i); #1;
            if (e == 5) begin
                chk("d saturated pending", pend_d, 3);
                chk("d overflow set", ovf_d, 1);
            end
            @(negedge clk_i); trig_d[0] = 1'b0;
        end
        for (int t = 0; t < 1000 && cnt_d < 4; t++) @(negedge clk_i);
        repeat (80) @(negedge clk_i);
        chk("d pulses", cnt_d, 4);
        chk("d pending idle", pend_d, 0);
        chk("d overflow sticky", ovf_d, 1);
        clr_d[0] = 1'b1;
        @(posedge clk_i); #1;
        chk("d overflow cleared", ovf_d, 0);
        @(negedge clk_i); clr_d[0] = 1'b0;

        // A: both resets asserted mid-transfer
        trig_a[0] = 1'b1;
        @(negedge clk_i); trig_a[0] = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1; rst_s = 1'b1;
        #1;
        chk("mid reset pend_a", pend_a, 0);
        chk("mid reset ovf_a", ovf_a, 0);
        chk("mid reset to_a", to_a, 0);
        repeat (4) @(negedge clk_i);
        rst_i = 1'b0; rst_s = 1'b0;
        repeat (3) @(negedge clk_i);
        base0 = cnt_a[0];
        trig_a[0] = 1'b1;
        @(negedge clk_i); trig_a[0] = 1'b0;
        for (int t = 0; t < 200 && cnt_a[0] < base0 + 1; t++) @(negedge clk_i);
        repeat (60) @(negedge clk_i);
        chk("post reset pulses ch0", cnt_a[0] - base0, 1);
        chk("post reset pending", pend_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
